// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler.
// Arbitrates between ARP reply requests (receive path) and resolve requests (cache-miss
// logic), builds the header fields for the 28-byte ARP frame transmitter, pulses tx_start and
// follows the transmitter busy flag to completion. It also owns the single outstanding
// resolve: its retry timer, its attempt counter, and its cancellation on resolution.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   local_mac, local_ip   own addresses, sampled at grant
//   rep_valid/mac/ip      reply request; rep_ready high in the cycle it is granted
//   req_valid/ip          resolve request; req_ready high in the cycle it is accepted
//   resolve_valid/ip      cache learned a mapping; cancels a matching pending request
//   req_fail, fail_ip     one-cycle pulse when the pending request is abandoned
//   tx_start, tx_busy     transmitter handshake
//   hdr_type .. target_ip_addr  frame fields, stable from grant until back in idle
//   busy                  scheduler not idle
module arp_tx_sched #(
   parameter int unsigned RETRY_CYCLES = 1000,
   parameter int unsigned MAX_TRIES    = 3,
   parameter int unsigned TIMER_W      = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] local_mac,
   input  logic [31:0] local_ip,
   input  logic        rep_valid,
   input  logic [47:0] rep_mac,
   input  logic [31:0] rep_ip,
   output logic        rep_ready,
   input  logic        req_valid,
   input  logic [31:0] req_ip,
   output logic        req_ready,
   input  logic        resolve_valid,
   input  logic [31:0] resolve_ip,
   output logic        req_fail,
   output logic [31:0] fail_ip,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [15:0] hdr_type,
   output logic [15:0] proto_type,
   output logic [7:0]  hdr_addr_length,
   output logic [7:0]  pro_addr_length,
   output logic [15:0] operation,
   output logic [47:0] send_hdr_addr,
   output logic [31:0] send_ip_addr,
   output logic [47:0] target_hdr_addr,
   output logic [31:0] target_ip_addr,
   output logic        busy
);

   localparam int unsigned ATT_W = $clog2(MAX_TRIES + 1);
   localparam logic [ATT_W-1:0]   MaxTries  = ATT_W'(MAX_TRIES);
   localparam logic [TIMER_W-1:0] RetryLoad = TIMER_W'(RETRY_CYCLES);

   typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

   state_e               state_q, state_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [31:0]          pend_ip_q, pend_ip_d;
   logic [ATT_W-1:0]     attempts_q, attempts_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 last_grant_q, last_grant_d;  // 1: reply class granted last
   logic                 cur_req_q, cur_req_d;        // frame in flight is a resolve request

   logic [15:0] hdr_type_q, proto_type_q, operation_q;
   logic [7:0]  hdr_len_q, pro_len_q;
   logic [47:0] sha_q, tha_q;
   logic [31:0] spa_q, tpa_q;

   logic in_idle, resolve_hit, retry_due, req_new, rep_cand, req_cand;
   logic grant_rep, grant_req, give_up, frame_done;

   // Arbitration and pending-request control. rst_n gates the handshakes so that nothing is
   // accepted in a cycle whose grant the reset will discard.
   always_comb begin
      in_idle     = (state_q == StIdle);
      resolve_hit = resolve_valid & pend_valid_q & (resolve_ip == pend_ip_q);
      retry_due   = pend_valid_q & (timer_q == '0) & (attempts_q < MaxTries) & ~resolve_hit;
      req_new     = req_valid & ~pend_valid_q;
      rep_cand    = rst_n & in_idle & rep_valid;
      req_cand    = rst_n & in_idle & (req_new | retry_due);
      grant_rep   = rep_cand & (~req_cand | ~last_grant_q);
      grant_req   = req_cand & ~grant_rep;
      give_up     = rst_n & in_idle & pend_valid_q & (timer_q == '0) &
                    (attempts_q == MaxTries) & ~resolve_hit;
      frame_done  = (state_q == StWaitDone) & ~tx_busy;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_req_d    = cur_req_q;
      unique case (state_q)
         StIdle: begin
            if (grant_rep || grant_req) begin
               state_d      = StStart;
               last_grant_d = grant_rep;
               cur_req_d    = grant_req;
            end
         end
         StStart:    state_d = StWaitBusy;
         StWaitBusy: if (tx_busy) state_d = StWaitDone;
         StWaitDone: if (!tx_busy) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_ip_d    = pend_ip_q;
      attempts_d   = attempts_q;
      timer_d      = timer_q;
      if (pend_valid_q && (timer_q != '0)) timer_d = timer_q - TIMER_W'(1);
      if (resolve_hit || give_up) pend_valid_d = 1'b0;
      if (grant_req) begin
         if (req_new) begin
            pend_valid_d = 1'b1;
            pend_ip_d    = req_ip;
            attempts_d   = ATT_W'(1);
            timer_d      = '0;
         end else begin
            attempts_d = attempts_q + ATT_W'(1);
         end
      end
      // A request resolved while its frame was in flight gets no retry window.
      if (frame_done && cur_req_q && pend_valid_q && !resolve_hit) timer_d = RetryLoad;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pend_valid_q <= 1'b0;
         pend_ip_q    <= '0;
         attempts_q   <= '0;
         timer_q      <= '0;
         last_grant_q <= 1'b0;
         cur_req_q    <= 1'b0;
         hdr_type_q   <= '0;
         proto_type_q <= '0;
         hdr_len_q    <= '0;
         pro_len_q    <= '0;
         operation_q  <= '0;
         sha_q        <= '0;
         spa_q        <= '0;
         tha_q        <= '0;
         tpa_q        <= '0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_ip_q    <= pend_ip_d;
         attempts_q   <= attempts_d;
         timer_q      <= timer_d;
         last_grant_q <= last_grant_d;
         cur_req_q    <= cur_req_d;
         if (grant_rep || grant_req) begin
            hdr_type_q   <= 16'h0001;
            proto_type_q <= 16'h0800;
            hdr_len_q    <= 8'd6;
            pro_len_q    <= 8'd4;
            sha_q        <= local_mac;
            spa_q        <= local_ip;
            operation_q  <= grant_rep ? 16'd2 : 16'd1;
            tha_q        <= grant_rep ? rep_mac : 48'd0;
            tpa_q        <= grant_rep ? rep_ip : (req_new ? req_ip : pend_ip_q);
         end
      end
   end

   assign rep_ready       = grant_rep;
   assign req_ready       = grant_req & req_new;
   assign req_fail        = give_up;
   assign fail_ip         = give_up ? pend_ip_q : 32'd0;
   assign tx_start        = (state_q == StStart);
   assign busy            = (state_q != StIdle);
   assign hdr_type        = hdr_type_q;
   assign proto_type      = proto_type_q;
   assign hdr_addr_length = hdr_len_q;
   assign pro_addr_length = pro_len_q;
   assign operation       = operation_q;
   assign send_hdr_addr   = sha_q;
   assign send_ip_addr    = spa_q;
   assign target_hdr_addr = tha_q;
   assign target_ip_addr  = tpa_q;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Bench for arp_tx_sched: a vector table of single transactions plus hand-written sequences
// for retry, give-up, cancellation, alternation and reset. A transmitter model answers
// tx_start; a negedge monitor compares every started frame against a queue of expected frames.
module tb_arp_tx_sched;

   localparam int unsigned RetryCycles = 20;
   localparam int unsigned MaxTries    = 3;
   localparam int          BusyLen     = 7;
   localparam logic [47:0] LocalMac    = 48'h02005E000001;

   logic        clk, rst_n;
   logic [47:0] local_mac, rep_mac;
   logic [31:0] local_ip, rep_ip, req_ip, resolve_ip, fail_ip;
   logic        rep_valid, rep_ready, req_valid, req_ready, resolve_valid, req_fail;
   logic        tx_start, tx_busy, busy;
   logic [15:0] hdr_type, proto_type, operation;
   logic [7:0]  hdr_addr_length, pro_addr_length;
   logic [47:0] send_hdr_addr, target_hdr_addr;
   logic [31:0] send_ip_addr, target_ip_addr;

   arp_tx_sched #(.RETRY_CYCLES(RetryCycles), .MAX_TRIES(MaxTries), .TIMER_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .local_mac(local_mac), .local_ip(local_ip),
      .rep_valid(rep_valid), .rep_mac(rep_mac), .rep_ip(rep_ip), .rep_ready(rep_ready),
      .req_valid(req_valid), .req_ip(req_ip), .req_ready(req_ready),
      .resolve_valid(resolve_valid), .resolve_ip(resolve_ip),
      .req_fail(req_fail), .fail_ip(fail_ip), .tx_start(tx_start), .tx_busy(tx_busy),
      .hdr_type(hdr_type), .proto_type(proto_type), .hdr_addr_length(hdr_addr_length),
      .pro_addr_length(pro_addr_length), .operation(operation),
      .send_hdr_addr(send_hdr_addr), .send_ip_addr(send_ip_addr),
      .target_hdr_addr(target_hdr_addr), .target_ip_addr(target_ip_addr), .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   int cyc = 0, tx_cnt = 0, fail_cnt = 0, rep_rdy_cnt = 0, req_rdy_cnt = 0, fail_cyc = 0;
   int start_q[$];
   int done_q[$];
   logic [31:0]  fail_ip_seen;
   logic         prev_busy = 1'b0, prev_start = 1'b0;
   logic [223:0] sb[$];
   logic [223:0] exp_fr;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [223:0] frame(input logic [15:0] op, input logic [31:0] spa,
                                          input logic [47:0] tha, input logic [31:0] tpa);
      return {16'h0001, 16'h0800, 8'd6, 8'd4, op, LocalMac, spa, tha, tpa};
   endfunction

   // Transmitter model: raises tx_busy when it sees tx_start and holds it BusyLen cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            tx_busy = 1'b1;
            repeat (BusyLen) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   // Monitor and scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rep_ready) rep_rdy_cnt++;
         if (req_ready) req_rdy_cnt++;
         if (tx_start) begin
            tx_cnt++;
            start_q.push_back(cyc);
            chk("tx_start_one_cycle", prev_start, 1'b0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_start: tx_start at cycle %0d, expected none", cyc);
            end else begin
               exp_fr = sb.pop_front();
               chk("frame_fields", {hdr_type, proto_type, hdr_addr_length, pro_addr_length,
                   operation, send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr},
                   exp_fr);
            end
         end
         if (prev_busy && !busy) done_q.push_back(cyc);
         if (req_fail) begin
            fail_cnt++;
            fail_ip_seen = fail_ip;
            fail_cyc = cyc;
         end
         prev_busy  = busy;
         prev_start = tx_start;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      tx_cnt = 0; fail_cnt = 0; rep_rdy_cnt = 0; req_rdy_cnt = 0;
      start_q.delete();
      done_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_tx(input int n, input string name);
      int k = 0;
      while (tx_cnt < n && k < 200) begin step(); k++; end
      chk(name, tx_cnt >= n, 1'b1);
   endtask

   task automatic wait_done(input int n, input string name);
      int k = 0;
      while (done_q.size() < n && k < 200) begin step(); k++; end
      chk(name, done_q.size() >= n, 1'b1);
   endtask

   task automatic wait_fail(input int n, input string name);
      int k = 0;
      while (fail_cnt < n && k < 200) begin step(); k++; end
      chk(name, fail_cnt >= n, 1'b1);
   endtask

   task automatic cancel(input logic [31:0] ip);
      resolve_ip = ip;
      resolve_valid = 1'b1;
      step();
      resolve_valid = 1'b0;
   endtask

   // New resolve request: checks acceptance and queues the expected frame(s).
   task automatic new_req(input logic [31:0] ip, input int frames, input string name);
      req_valid = 1'b1;
      req_ip = ip;
      for (int f = 0; f < frames; f++) sb.push_back(frame(16'd1, local_ip, 48'd0, ip));
      @(negedge clk);
      chk(name, req_ready, 1'b1);
      step();
      req_valid = 1'b0;
   endtask

   typedef struct {
      bit          is_rep;
      logic [47:0] mac;
      logic [31:0] ip;
      logic [31:0] lip;
      logic [1:0]  exp_rdy;
      logic [15:0] exp_op;
      logic [47:0] exp_tha;
      logic [31:0] exp_tpa;
   } vec_t;
   vec_t vecs[5];

   initial begin
      vecs[0] = '{1'b1, 48'h112233445566, 32'h0A000002, 32'h0A000001, 2'b10, 16'd2,
                  48'h112233445566, 32'h0A000002};
      vecs[1] = '{1'b0, 48'h0, 32'h0A000010, 32'h0A000001, 2'b01, 16'd1, 48'h0, 32'h0A000010};
      vecs[2] = '{1'b1, 48'hAABBCCDDEEFF, 32'hC0A80001, 32'hC0A800FE, 2'b10, 16'd2,
                  48'hAABBCCDDEEFF, 32'hC0A80001};
      vecs[3] = '{1'b0, 48'h0, 32'hC0A80105, 32'hC0A800FE, 2'b01, 16'd1, 48'h0, 32'hC0A80105};
      vecs[4] = '{1'b1, 48'hFFFFFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2'b10, 16'd2,
                  48'hFFFFFFFFFFFF, 32'hFFFFFFFF};

      rst_n = 1'b0; local_mac = LocalMac; local_ip = 32'h0A000001;
      rep_valid = 1'b0; rep_mac = '0; rep_ip = '0; req_valid = 1'b0; req_ip = '0;
      resolve_valid = 1'b0; resolve_ip = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_ctrl", {busy, tx_start, rep_ready, req_ready, req_fail, fail_ip}, 0);
      chk("rst_fields", {hdr_type, proto_type, hdr_addr_length, pro_addr_length, operation,
          send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr}, 0);
      step();
      rst_n = 1'b1;
      step();

      // Single transactions from the table; inputs are scrambled after grant.
      for (int i = 0; i < 5; i++) begin
         clear_mon();
         local_ip = vecs[i].lip;
         if (vecs[i].is_rep) begin
            rep_valid = 1'b1; rep_mac = vecs[i].mac; rep_ip = vecs[i].ip;
         end else begin
            req_valid = 1'b1; req_ip = vecs[i].ip;
         end
         sb.push_back(frame(vecs[i].exp_op, vecs[i].lip, vecs[i].exp_tha, vecs[i].exp_tpa));
         @(negedge clk);
         chk("vec_ready", {rep_ready, req_ready}, vecs[i].exp_rdy);
         step();
         rep_valid = 1'b0; req_valid = 1'b0;
         local_ip = ~vecs[i].lip; rep_mac = ~vecs[i].mac; rep_ip = ~vecs[i].ip;
         req_ip = ~vecs[i].ip;
         wait_tx(1, "vec_tx_start");
         wait_done(1, "vec_done");
         chk("vec_ready_cycles", rep_rdy_cnt + req_rdy_cnt, 1);
         chk("vec_start_count", tx_cnt, 1);
         if (!vecs[i].is_rep) cancel(vecs[i].ip);
      end
      local_ip = 32'h0A000001;

      // Give-up: three transmissions, each retry RETRY_CYCLES of countdown plus the grant
      // cycle after the previous frame ends, then the fail pulse when the last window lapses.
      do_reset();
      clear_mon();
      new_req(32'h0A000005, 3, "gu_req_ready");
      wait_done(1, "gu_done1");
      repeat (5) step();
      cancel(32'h0A000009);  // non-matching, must be ignored
      wait_tx(3, "gu_tx3");
      wait_done(3, "gu_done3");
      wait_fail(1, "gu_fail");
      chk("gu_retry1_gap", start_q[1] - done_q[0], RetryCycles + 1);
      chk("gu_retry2_gap", start_q[2] - done_q[1], RetryCycles + 1);
      chk("gu_fail_gap", fail_cyc - done_q[2], RetryCycles);
      chk("gu_fail_ip", fail_ip_seen, 32'h0A000005);
      repeat (40) step();
      chk("gu_tx_total", tx_cnt, 3);
      chk("gu_fail_once", fail_cnt, 1);

      // Resolution during the first retry wait cancels the request.
      do_reset();
      clear_mon();
      new_req(32'h0A000005, 1, "res_req_ready");
      wait_done(1, "res_done1");
      repeat (5) step();
      cancel(32'h0A000005);
      repeat (40) step();
      chk("res_no_retry", tx_cnt, 1);
      chk("res_no_fail", fail_cnt, 0);
      new_req(32'h0A000006, 1, "res_new_req_ready");
      wait_tx(2, "res_new_tx");
      wait_done(2, "res_new_done");
      cancel(32'h0A000006);

      // Resolution in the exact cycle the retry becomes due.
      do_reset();
      clear_mon();
      new_req(32'h0A000005, 1, "hit_req_ready");
      wait_done(1, "hit_done1");
      repeat (RetryCycles - 1) step();
      resolve_ip = 32'h0A000005;
      resolve_valid = 1'b1;
      step();
      resolve_valid = 1'b0;
      repeat (40) step();
      chk("hit_no_retry", tx_cnt, 1);
      chk("hit_no_fail", fail_cnt, 0);
      new_req(32'h0A000008, 1, "hit_pend_cleared");
      wait_tx(2, "hit_new_tx");
      wait_done(2, "hit_new_done");
      cancel(32'h0A000008);

      // Both classes held from reset: reply, request, reply; request accepted once.
      clear_mon();
      rst_n = 1'b0;
      rep_valid = 1'b1; rep_mac = 48'h112233445566; rep_ip = 32'h0A000002;
      req_valid = 1'b1; req_ip = 32'h0A000007;
      step();
      @(negedge clk);
      chk("rst_ready_gated", {rep_ready, req_ready}, 2'b00);
      sb.push_back(frame(16'd2, 32'h0A000001, 48'h112233445566, 32'h0A000002));
      sb.push_back(frame(16'd1, 32'h0A000001, 48'd0, 32'h0A000007));
      sb.push_back(frame(16'd2, 32'h0A000001, 48'h112233445566, 32'h0A000002));
      step();
      rst_n = 1'b1;
      wait_tx(3, "alt_tx3");
      rep_valid = 1'b0;
      req_valid = 1'b0;
      cancel(32'h0A000007);
      repeat (40) step();
      chk("alt_tx_total", tx_cnt, 3);
      chk("alt_req_ready_once", req_rdy_cnt, 1);
      chk("alt_rep_ready", rep_rdy_cnt, 2);

      // Reset while waiting for the transmitter to finish.
      do_reset();
      clear_mon();
      new_req(32'h0A000005, 1, "rw_req_ready");
      wait_tx(1, "rw_tx1");
      step();
      step();
      rst_n = 1'b0;
      step();
      @(negedge clk);
      chk("rw_ctrl_zero", {busy, tx_start, rep_ready, req_ready, req_fail, fail_ip}, 0);
      chk("rw_fields_zero", {hdr_type, proto_type, hdr_addr_length, pro_addr_length,
          operation, send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr}, 0);
      step();
      rst_n = 1'b1;
      repeat (60) step();
      chk("rw_no_retry", tx_cnt, 1);
      chk("rw_no_fail", fail_cnt, 0);
      new_req(32'h0A00000C, 1, "rw_pend_dropped");
      wait_tx(2, "rw_new_tx");
      wait_done(2, "rw_new_done");
      cancel(32'h0A00000C);

      step();
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
